// File: rtl/seat_popup_scheduler_pkg.sv
// Purpose: shared seat-grid geometry, FSM encoding and frame-tick line for the pop-up game.
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a.
package seat_popup_scheduler_pkg;

  // Seat grid geometry, shared with the sprite renderer and the HUD.
  localparam int NUM_COLS  = 4;
  localparam int NUM_ROWS  = 2;
  localparam int NUM_SEATS = NUM_COLS * NUM_ROWS;
  localparam int GRID_X0   = 451;
  localparam int GRID_Y0   = 366;
  localparam int PITCH     = 50;

  // First line after the active display; the frame tick fires when vCount enters it.
  localparam logic [9:0] TICK_LINE = 10'd480;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HIDDEN = 2'd1,
    ST_SHOWN  = 2'd2,
    ST_HIT    = 2'd3
  } popup_state_t;

  // Left column of the sprite when parked on the given seat.
  function automatic logic [9:0] seat_x(input logic [2:0] seat);
    int col;
    col = int'(seat) % NUM_COLS;
    return 10'(GRID_X0 + col * PITCH);
  endfunction

  // Top line of the sprite when parked on the given seat.
  function automatic logic [9:0] seat_y(input logic [2:0] seat);
    int row;
    row = int'(seat) / NUM_COLS;
    return 10'(GRID_Y0 + row * PITCH);
  endfunction

  // Random seat that never repeats the current one, so the sprite always visibly moves.
  function automatic logic [2:0] pick_seat(input logic [2:0] rnd, input logic [2:0] cur);
    int cand;
    cand = int'(rnd) % NUM_SEATS;
    if (cand == int'(cur)) begin
      cand = (cand + 1) % NUM_SEATS;
    end
    return 3'(cand);
  endfunction

endpackage

// File: rtl/seat_popup_scheduler_lfsr16.sv
// Purpose: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used for seat selection.
// Latency: new value every clk; q is the registered state.
// Backpressure: none, never stalls.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic feedback;

  assign feedback = q[15] ^ q[13] ^ q[12] ^ q[10];

  // Shift left, feeding the tap XOR into bit 0; seed must be nonzero or it locks up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= SEED;
    end else begin
      q <= {q[14:0], feedback};
    end
  end

endmodule

// File: rtl/seat_popup_scheduler.sv
// Purpose: per-frame hide/show/hit sequencer for the pop-up seat sprite, with saturating HUD scores.
// Latency: position/visibility change 1 clk after a frame tick; hit_ack 1 clk after hit_req.
// Backpressure: none; hit_req pulses outside SHOWN or on the wrong seat are dropped.
module seat_popup_scheduler
  import seat_popup_scheduler_pkg::*;
#(
  parameter int          HIDE_FRAMES = 30,
  parameter int          SHOW_FRAMES = 60,
  parameter int          HIT_FRAMES  = 15,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] vCount,
  input  logic       enable,
  input  logic       clear_score,
  input  logic       hit_req,
  input  logic [2:0] hit_seat,
  output logic [9:0] sprite_x,
  output logic [9:0] sprite_y,
  output logic       sprite_vis,
  output logic       sprite_flash,
  output logic       hit_ack,
  output logic [7:0] score,
  output logic [7:0] miss_count
);

  // Frame counts are compared against the last tick index of each state.
  localparam logic [7:0] HIDE_LAST = 8'(HIDE_FRAMES - 1);
  localparam logic [7:0] SHOW_LAST = 8'(SHOW_FRAMES - 1);
  localparam logic [7:0] HIT_LAST  = 8'(HIT_FRAMES - 1);

  popup_state_t state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [9:0]   vcount_q;
  logic         frame_tick;
  logic [2:0]   seat_q;
  logic [15:0]  lfsr_q;
  logic         hit_ok;
  logic         latch_seat;
  logic         score_inc;
  logic         miss_inc;
  logic         unused_lfsr_bits;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  // Only the low bits feed seat selection; the rest just give the sequence its length.
  assign unused_lfsr_bits = ^lfsr_q[15:3];

  // Edge-detect on entering TICK_LINE so one frame gives one tick regardless of pixel rate.
  assign frame_tick = (vCount == TICK_LINE) && (vcount_q != TICK_LINE);
  assign hit_ok     = hit_req && (hit_seat == seat_q);

  // Remember the previous line number for the tick edge detector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vcount_q <= '0;
    end else begin
      vcount_q <= vCount;
    end
  end

  // State and per-state frame counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic, score events and Moore outputs; a correct hit beats a same-cycle timeout.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    latch_seat   = 1'b0;
    score_inc    = 1'b0;
    miss_inc     = 1'b0;
    sprite_vis   = (state_q == ST_SHOWN) || (state_q == ST_HIT);
    sprite_flash = (state_q == ST_HIT);

    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_HIDDEN;
          cnt_d   = '0;
        end
        ST_HIDDEN: begin
          if (frame_tick) begin
            if (cnt_q == HIDE_LAST) begin
              latch_seat = 1'b1;
              state_d    = ST_SHOWN;
              cnt_d      = '0;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        ST_SHOWN: begin
          if (hit_ok) begin
            score_inc = 1'b1;
            state_d   = ST_HIT;
            cnt_d     = '0;
          end else if (frame_tick) begin
            if (cnt_q == SHOW_LAST) begin
              miss_inc = 1'b1;
              state_d  = ST_HIDDEN;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        ST_HIT: begin
          if (frame_tick) begin
            if (cnt_q == HIT_LAST) begin
              state_d = ST_HIDDEN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Seat and its pixel position move together, only on the tick that reveals the sprite.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seat_q   <= '0;
      sprite_x <= 10'(GRID_X0);
      sprite_y <= 10'(GRID_Y0);
    end else if (latch_seat) begin
      seat_q   <= pick_seat(lfsr_q[2:0], seat_q);
      sprite_x <= seat_x(pick_seat(lfsr_q[2:0], seat_q));
      sprite_y <= seat_y(pick_seat(lfsr_q[2:0], seat_q));
    end
  end

  // One-cycle acknowledge of an accepted hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_ack <= 1'b0;
    end else begin
      hit_ack <= score_inc;
    end
  end

  // Saturating HUD counters; a clear in the same cycle as an increment wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score      <= '0;
      miss_count <= '0;
    end else if (clear_score) begin
      score      <= '0;
      miss_count <= '0;
    end else begin
      if (score_inc && (score != 8'hFF)) begin
        score <= score + 8'd1;
      end
      if (miss_inc && (miss_count != 8'hFF)) begin
        miss_count <= miss_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_seat_popup_scheduler.sv
// Purpose: randomized self-checking bench for seat_popup_scheduler against a frame-level model.
// Latency: outputs compared 1 ns after every rising clk edge.
// Backpressure: n/a.
module tb_seat_popup_scheduler;

  localparam int          HIDE = 2;
  localparam int          SHOW = 5;
  localparam int          HITF = 3;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [9:0]  TL   = 10'd480;

  // Model phases: off, waiting hidden, sprite up, sprite struck.
  localparam int M_OFF = 0, M_WAIT = 1, M_UP = 2, M_STRUCK = 3;

  logic       clk;
  logic       rst;
  logic [9:0] vCount;
  logic       enable;
  logic       clear_score;
  logic       hit_req;
  logic [2:0] hit_seat;
  logic [9:0] sprite_x;
  logic [9:0] sprite_y;
  logic       sprite_vis;
  logic       sprite_flash;
  logic       hit_ack;
  logic [7:0] score;
  logic [7:0] miss_count;

  seat_popup_scheduler #(
    .HIDE_FRAMES (HIDE),
    .SHOW_FRAMES (SHOW),
    .HIT_FRAMES  (HITF),
    .LFSR_SEED   (SEED)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .vCount       (vCount),
    .enable       (enable),
    .clear_score  (clear_score),
    .hit_req      (hit_req),
    .hit_seat     (hit_seat),
    .sprite_x     (sprite_x),
    .sprite_y     (sprite_y),
    .sprite_vis   (sprite_vis),
    .sprite_flash (sprite_flash),
    .hit_ack      (hit_ack),
    .score        (score),
    .miss_count   (miss_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_st, m_cnt, m_score, m_miss, m_x, m_y;
  bit          m_ack;
  int          m_seat;
  logic [15:0] m_lfsr;
  logic [9:0]  m_prev_v;
  int          m_acks;

  function automatic void m_reset();
    m_st = M_OFF; m_cnt = 0; m_score = 0; m_miss = 0;
    m_x = 451; m_y = 366; m_seat = 0; m_ack = 1'b0;
    m_lfsr = SEED; m_prev_v = 10'd0;
  endfunction

  // One clk edge: m_cnt counts ticks seen so far in the current phase.
  function automatic void m_step();
    bit tick, add_hit, add_miss;
    int cand;
    tick     = (vCount == TL) && (m_prev_v != TL);
    m_prev_v = vCount;
    m_ack    = 1'b0;
    add_hit  = 1'b0;
    add_miss = 1'b0;
    if (!enable) begin
      m_st = M_OFF; m_cnt = 0;
    end else if (m_st == M_OFF) begin
      m_st = M_WAIT; m_cnt = 0;
    end else if (m_st == M_WAIT) begin
      if (tick) begin
        m_cnt++;
        if (m_cnt == HIDE) begin
          cand = int'(m_lfsr) % 8;
          if (cand == m_seat) cand = (cand + 1) % 8;
          m_seat = cand;
          m_x = 451 + (cand % 4) * 50;
          m_y = 366 + (cand / 4) * 50;
          m_st = M_UP; m_cnt = 0;
        end
      end
    end else if (m_st == M_UP) begin
      if (hit_req && int'(hit_seat) == m_seat) begin
        m_ack = 1'b1; add_hit = 1'b1; m_st = M_STRUCK; m_cnt = 0;
      end else if (tick) begin
        m_cnt++;
        if (m_cnt == SHOW) begin
          add_miss = 1'b1; m_st = M_WAIT; m_cnt = 0;
        end
      end
    end else begin
      if (tick) begin
        m_cnt++;
        if (m_cnt == HITF) begin
          m_st = M_WAIT; m_cnt = 0;
        end
      end
    end
    if (clear_score) begin
      m_score = 0; m_miss = 0;
    end else begin
      if (add_hit && m_score < 255) m_score++;
      if (add_miss && m_miss < 255) m_miss++;
    end
    if (m_ack) m_acks++;
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endfunction

  task automatic compare_all();
    chk("vis",   sprite_vis,   (m_st == M_UP || m_st == M_STRUCK));
    chk("flash", sprite_flash, (m_st == M_STRUCK));
    chk("ack",   hit_ack,      m_ack);
    chk("score", score,        m_score);
    chk("miss",  miss_count,   m_miss);
    chk("x",     sprite_x,     m_x);
    chk("y",     sprite_y,     m_y);
  endtask

  task automatic cycle();
    @(posedge clk);
    m_step();
    #1;
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_vis"},   sprite_vis,   0);
    chk({tag, "_flash"}, sprite_flash, 0);
    chk({tag, "_ack"},   hit_ack,      0);
    chk({tag, "_score"}, score,        0);
    chk({tag, "_miss"},  miss_count,   0);
    chk({tag, "_x"},     sprite_x,     451);
    chk({tag, "_y"},     sprite_y,     366);
  endtask

  // ---------------- stimulus ----------------
  int k_hit_ok, k_hit_bad, k_clear;
  bit k_disable, k_race;
  int race_hits;

  task automatic drive();
    int r;
    if (vCount == TL) vCount = ($urandom_range(0, 99) < 40) ? TL : 10'($urandom_range(0, 479));
    else              vCount = ($urandom_range(0, 99) < 35) ? TL : 10'($urandom_range(0, 479));
    hit_req  = 1'b0;
    hit_seat = 3'($urandom_range(0, 7));
    r = $urandom_range(0, 99);
    if (r < k_hit_ok) begin
      hit_req = 1'b1; hit_seat = 3'(m_seat);
    end else if (r < k_hit_ok + k_hit_bad) begin
      hit_req = 1'b1;
      if (int'(hit_seat) == m_seat) hit_seat = hit_seat + 3'd1;
    end
    clear_score = ($urandom_range(0, 99) < k_clear);
    if (k_disable && $urandom_range(0, 99) < 2) enable = ~enable;
    else if (!k_disable) enable = 1'b1;
    if (k_race && m_st == M_UP) begin
      hit_req = 1'b0;
      if (m_cnt == SHOW - 1 && vCount != TL) begin
        vCount = TL; hit_req = 1'b1; hit_seat = 3'(m_seat);
      end
    end
  endtask

  task automatic quiet_knobs();
    k_hit_ok = 0; k_hit_bad = 0; k_clear = 0; k_disable = 1'b0; k_race = 1'b0;
  endtask

  task automatic wait_for(input int target, input string tag);
    int n;
    n = 0;
    while (m_st != target && n < 2000) begin
      drive(); cycle(); n++;
    end
    chk({"reach_", tag}, (m_st == target), 1);
  endtask

  initial begin
    int sc, ms, n;
    rst = 1'b1; enable = 1'b0; clear_score = 1'b0; hit_req = 1'b0;
    hit_seat = 3'd0; vCount = 10'd0; m_acks = 0; race_hits = 0;
    quiet_knobs();
    m_reset();
    #1 rst = 1'b0;
    #1 check_reset_values("rst");
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // Enable, then two frame ticks reveal the sprite on the following clk.
    enable = 1'b1; vCount = 10'd0; cycle();
    vCount = TL;   cycle();
    chk("t1_vis_after_tick1", sprite_vis, 0);
    vCount = 10'd100; cycle();
    vCount = TL;      cycle();
    chk("t1_vis_after_tick2", sprite_vis, 1);

    // Mixed random play with wrong seats, clears and enable toggles.
    k_hit_ok = 15; k_hit_bad = 10; k_clear = 1; k_disable = 1'b1;
    repeat (3000) begin drive(); cycle(); end

    // Wrong-seat attempt while shown leaves the score alone.
    quiet_knobs();
    wait_for(M_UP, "up_wrong");
    sc = m_score;
    drive(); hit_req = 1'b1; hit_seat = 3'(m_seat) + 3'd1; cycle();
    chk("wrong_seat_score", score, sc);
    chk("wrong_seat_ack", hit_ack, 0);

    // Correct hit landing on the timeout tick: hit wins, no miss.
    quiet_knobs(); k_race = 1'b1;
    n = 0;
    while (race_hits < 3 && n < 5000) begin
      drive();
      if (hit_req && m_st == M_UP) begin
        ms = m_miss; sc = m_score;
        cycle();
        chk("race_miss", miss_count, ms);
        chk("race_score", score, (sc < 255) ? sc + 1 : 255);
        race_hits++;
      end else begin
        cycle();
      end
      n++;
    end
    chk("race_seen", (race_hits >= 3), 1);

    // Drive the score into saturation and keep hitting.
    quiet_knobs(); k_hit_ok = 40;
    n = 0;
    while (m_score < 255 && n < 30000) begin drive(); cycle(); n++; end
    sc = m_acks;
    while (m_acks < sc + 2 && n < 30000) begin drive(); cycle(); n++; end
    chk("sat_score", score, 255);

    // Clear arriving with a correct hit.
    quiet_knobs();
    wait_for(M_UP, "up_clear");
    drive(); hit_req = 1'b1; hit_seat = 3'(m_seat); clear_score = 1'b1; cycle();
    chk("clr_hit_score", score, 0);
    chk("clr_hit_miss", miss_count, 0);
    chk("clr_hit_ack", hit_ack, 1);

    // Disable while shown hides the sprite on the next clk.
    quiet_knobs();
    wait_for(M_UP, "up_dis");
    drive(); enable = 1'b0; hit_req = 1'b0; cycle();
    chk("dis_vis", sprite_vis, 0);
    chk("dis_flash", sprite_flash, 0);
    drive(); enable = 1'b1; cycle();

    // Asynchronous reset in the middle of HIT.
    quiet_knobs();
    wait_for(M_UP, "up_rst");
    drive(); hit_req = 1'b1; hit_seat = 3'(m_seat); cycle();
    chk("pre_rst_flash", sprite_flash, 1);
    #2 rst = 1'b0;
    #1 check_reset_values("async_rst");
    m_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    k_hit_ok = 20; k_hit_bad = 10; k_clear = 1;
    repeat (300) begin drive(); cycle(); end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
